// File: rtl/dawg_domain_sequencer_if.sv
// Request/response bundle between the domain sequencer and its neighbours:
// partition-table config port, OS switch port, user lookup port, and the
// downstream cacheline control signals.
// slave  = sequencer side, master = driver/consumer side.
interface dawg_domain_sequencer_if #(
  parameter int NUM_WAYS   = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DOM_W      = 2
);
  logic                  cfg_we;
  logic [DOM_W-1:0]      cfg_dom;
  logic [NUM_WAYS-1:0]   cfg_hitmap;
  logic                  cfg_err;
  logic                  sw_valid;
  logic [DOM_W-1:0]      sw_dom;
  logic                  sw_ready;
  logic                  req_valid;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_ready;
  logic                  rsp_valid;
  logic                  rsp_hit;
  logic [DOM_W-1:0]      cur_dom;
  logic                  os_req;
  logic [NUM_WAYS-1:0]   hitmap;
  logic                  user_req;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  hit;

  modport slave (
    input  cfg_we, cfg_dom, cfg_hitmap, sw_valid, sw_dom, req_valid, req_addr, hit,
    output cfg_err, sw_ready, req_ready, rsp_valid, rsp_hit, cur_dom,
           os_req, hitmap, user_req, addr
  );

  modport master (
    output cfg_we, cfg_dom, cfg_hitmap, sw_valid, sw_dom, req_valid, req_addr, hit,
    input  cfg_err, sw_ready, req_ready, rsp_valid, rsp_hit, cur_dom,
           os_req, hitmap, user_req, addr
  );
endinterface

// File: rtl/dawg_domain_sequencer.sv
// DAWG domain sequencer: owns the per-domain way-partition table, programs the
// cacheline's active hitmap on OS context switches, and serialises one user
// lookup at a time into the cacheline.
//
// Optional build macro: DAWG_SAME_DOMAIN_SKIP_EN
//   defined   - a switch to the already-active domain is absorbed in IDLE
//               without an os_req pulse.
//   undefined - every accepted switch pulses os_req and reloads the entry.
//
// State  | meaning
// -------+-----------------------------------------------------------------
// INIT   | first cycle after reset release: load table[0] into the cacheline
// IDLE   | accept a context switch (priority) or a user lookup
// SWITCH | os_req pulse, cacheline loads the new hitmap
// LOOKUP | user_req pulse with the latched address
// WAIT   | cacheline returns hit; registered into rsp_hit / rsp_valid
module dawg_domain_sequencer #(
  parameter int NUM_WAYS    = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_DOMAINS = 4,
  parameter int DOM_W       = 2
) (
  input logic                    clk,
  input logic                    reset,
  dawg_domain_sequencer_if.slave bus
);

  localparam int K = NUM_WAYS / NUM_DOMAINS;

  typedef enum logic [2:0] {INIT, IDLE, SWITCH, LOOKUP, WAIT} state_t;

  state_t                state;
  state_t                state_n;
  // Low during the reset-release cycle so INIT is only visible once the
  // block is actually running; keeps all outputs at 0 while in reset.
  logic                  run;

  logic [NUM_WAYS-1:0]   tbl [NUM_DOMAINS];
  logic [NUM_WAYS-1:0]   hitmap_q;
  logic [DOM_W-1:0]      cur_dom_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rsp_valid_q;
  logic                  rsp_hit_q;
  logic                  cfg_err_q;

  logic                  cfg_ok;
  logic                  sw_load;
  logic                  req_acc;
  logic                  sw_ready_c;
  logic                  req_ready_c;
  logic                  os_req_c;
  logic                  user_req_c;

  // Default partition: domain d owns K contiguous ways starting at d*K.
  function automatic logic [NUM_WAYS-1:0] part_mask(input int d);
    logic [NUM_WAYS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if ((i / K) == d) m[i] = 1'b1;
    end
    return m;
  endfunction

  // A table write is legal only if non-zero and disjoint from every other
  // domain's entry; the target's own old entry may be overlapped freely.
  always_comb begin
    cfg_ok = (bus.cfg_hitmap != '0);
    for (int j = 0; j < NUM_DOMAINS; j++) begin
      if ((DOM_W'(j) != bus.cfg_dom) && ((tbl[j] & bus.cfg_hitmap) != '0))
        cfg_ok = 1'b0;
    end
  end

  // Next-state and handshake/strobe decode.
  always_comb begin
    state_n     = state;
    sw_load     = 1'b0;
    req_acc     = 1'b0;
    sw_ready_c  = 1'b0;
    req_ready_c = 1'b0;
    os_req_c    = 1'b0;
    user_req_c  = 1'b0;
    case (state)
      INIT: begin
        os_req_c = run;
        if (run) state_n = IDLE;
      end
      IDLE: begin
        sw_ready_c  = 1'b1;
        req_ready_c = !bus.sw_valid;
        if (bus.sw_valid) begin
`ifdef DAWG_SAME_DOMAIN_SKIP_EN
          sw_load = (bus.sw_dom != cur_dom_q);
`else
          sw_load = 1'b1;
`endif
          if (sw_load) state_n = SWITCH;
        end else if (bus.req_valid) begin
          req_acc = 1'b1;
          state_n = LOOKUP;
        end
      end
      SWITCH: begin
        os_req_c = 1'b1;
        state_n  = IDLE;
      end
      LOOKUP: begin
        user_req_c = 1'b1;
        state_n    = WAIT;
      end
      WAIT: begin
        state_n = IDLE;
      end
      default: state_n = INIT;
    endcase
  end

  // State register and run flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= INIT;
      run   <= 1'b0;
    end else begin
      state <= state_n;
      run   <= 1'b1;
    end
  end

  // Active hitmap, current domain, latched lookup address and response.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hitmap_q    <= '0;
      cur_dom_q   <= '0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
    end else begin
      rsp_valid_q <= (state == WAIT);
      if (state == WAIT) rsp_hit_q <= bus.hit;
      if ((state == INIT) && !run) begin
        hitmap_q  <= tbl[0];
        cur_dom_q <= '0;
      end
      if (sw_load) begin
        hitmap_q  <= tbl[bus.sw_dom];
        cur_dom_q <= bus.sw_dom;
      end
      if (req_acc) addr_q <= bus.req_addr;
    end
  end

  // Partition table; writes never touch the active hitmap directly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int d = 0; d < NUM_DOMAINS; d++) tbl[d] <= part_mask(d);
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= bus.cfg_we && !cfg_ok;
      if (bus.cfg_we && cfg_ok) tbl[bus.cfg_dom] <= bus.cfg_hitmap;
    end
  end

  assign bus.cfg_err   = cfg_err_q;
  assign bus.sw_ready  = sw_ready_c;
  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_hit   = rsp_hit_q;
  assign bus.cur_dom   = cur_dom_q;
  assign bus.os_req    = os_req_c;
  assign bus.hitmap    = hitmap_q;
  assign bus.user_req  = user_req_c;
  assign bus.addr      = addr_q;

endmodule

// File: tb/tb_dawg_domain_sequencer.sv
// Directed bench for dawg_domain_sequencer with a small cacheline hit model
// and a response scoreboard.
module tb_dawg_domain_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic exp_q [$];

  dawg_domain_sequencer_if #(.NUM_WAYS(8), .ADDR_WIDTH(8), .DOM_W(2)) bus ();

  dawg_domain_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Cacheline model: hit when the low two address bits are non-zero.
  function automatic logic model_hit(input logic [7:0] a);
    return (a[1:0] != 2'b00);
  endfunction

  logic       ur = 1'b0;
  logic [7:0] ua = 8'h00;
  always @(negedge clk) begin
    ur = bus.user_req;
    ua = bus.addr;
  end
  always @(posedge clk) begin
    #1 bus.hit = ur && model_hit(ua);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every response strobe must match the oldest pushed lookup.
  always @(negedge clk) begin
    logic e;
    if (reset && bus.rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(bus.rsp_valid), 0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_hit_sb", 32'(bus.rsp_hit), 32'(e));
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_switch(input logic [1:0] dom, input logic [7:0] hm, input logic pulse);
    bus.sw_valid = 1'b1;
    bus.sw_dom   = dom;
    #1 check("sw_ready_accept", 32'(bus.sw_ready), 1);
    nxt();
    bus.sw_valid = 1'b0;
    check("sw_os_req", 32'(bus.os_req), 32'(pulse));
    check("sw_hitmap", 32'(bus.hitmap), 32'(hm));
    check("sw_cur_dom", 32'(bus.cur_dom), 32'(dom));
    check("sw_ready_busy", 32'(bus.sw_ready), 32'(!pulse));
    check("sw_no_user_req", 32'(bus.user_req), 0);
    if (pulse) begin
      nxt();
      check("sw_ready_again", 32'(bus.sw_ready), 1);
      check("sw_os_req_end", 32'(bus.os_req), 0);
    end
  endtask

  task automatic do_lookup(input logic [7:0] a, input logic with_rsp);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    #1 check("lk_req_ready", 32'(bus.req_ready), 1);
    if (with_rsp) exp_q.push_back(model_hit(a));
    nxt();
    bus.req_valid = 1'b0;
    check("lk_user_req", 32'(bus.user_req), 1);
    check("lk_addr", 32'(bus.addr), 32'(a));
    check("lk_no_os_req", 32'(bus.os_req), 0);
    check("lk_busy", 32'(bus.req_ready), 0);
    nxt();
    check("lk_wait_user_req", 32'(bus.user_req), 0);
    check("lk_wait_rsp", 32'(bus.rsp_valid), 0);
    if (with_rsp) begin
      nxt();
      check("lk_rsp_valid", 32'(bus.rsp_valid), 1);
      check("lk_rsp_hit", 32'(bus.rsp_hit), 32'(model_hit(a)));
      check("lk_ready_again", 32'(bus.req_ready), 1);
    end
  endtask

  task automatic cfg_write(input logic [1:0] dom, input logic [7:0] hm, input logic err);
    bus.cfg_we     = 1'b1;
    bus.cfg_dom    = dom;
    bus.cfg_hitmap = hm;
    nxt();
    bus.cfg_we = 1'b0;
    check("cfg_err", 32'(bus.cfg_err), 32'(err));
    nxt();
    check("cfg_err_clear", 32'(bus.cfg_err), 0);
  endtask

  initial begin
    bus.cfg_we     = 1'b0;
    bus.cfg_dom    = 2'd0;
    bus.cfg_hitmap = 8'h00;
    bus.sw_valid   = 1'b0;
    bus.sw_dom     = 2'd0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = 8'h00;

    // Reset values
    nxt();
    nxt();
    check("rst_os_req", 32'(bus.os_req), 0);
    check("rst_user_req", 32'(bus.user_req), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_sw_ready", 32'(bus.sw_ready), 0);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_hitmap", 32'(bus.hitmap), 0);
    check("rst_cur_dom", 32'(bus.cur_dom), 0);
    check("rst_addr", 32'(bus.addr), 0);
    check("rst_cfg_err", 32'(bus.cfg_err), 0);

    // INIT cycle, then IDLE
    reset = 1'b1;
    nxt();
    check("init_os_req", 32'(bus.os_req), 1);
    check("init_hitmap", 32'(bus.hitmap), 'h03);
    check("init_cur_dom", 32'(bus.cur_dom), 0);
    check("init_req_ready", 32'(bus.req_ready), 0);
    nxt();
    check("idle_os_req", 32'(bus.os_req), 0);
    check("idle_req_ready", 32'(bus.req_ready), 1);

    // Switch to domain 2
    do_switch(2'd2, 8'h30, 1'b1);

    // Back-to-back lookups: hit, miss, hit
    do_lookup(8'h5A, 1'b1);
    do_lookup(8'h40, 1'b1);
    do_lookup(8'hC3, 1'b1);

    // Rejected writes keep entry 1 at its reset value
    cfg_write(2'd1, 8'h01, 1'b1);
    cfg_write(2'd1, 8'h00, 1'b1);
    do_switch(2'd1, 8'h0C, 1'b1);
    // Legal write overlapping only its own old entry; active hitmap unchanged
    cfg_write(2'd1, 8'h04, 1'b0);
    check("cfg_no_hitmap_change", 32'(bus.hitmap), 'h0C);
    cfg_write(2'd0, 8'h80, 1'b1);
    do_switch(2'd3, 8'hC0, 1'b1);
    do_switch(2'd1, 8'h04, 1'b1);

    // Switch and request together: switch wins, request accepted 2 cycles later
    bus.sw_valid  = 1'b1;
    bus.sw_dom    = 2'd0;
    bus.req_valid = 1'b1;
    bus.req_addr  = 8'hA5;
    #1 check("both_req_ready", 32'(bus.req_ready), 0);
    check("both_sw_ready", 32'(bus.sw_ready), 1);
    nxt();
    bus.sw_valid = 1'b0;
    check("both_os_req", 32'(bus.os_req), 1);
    check("both_hitmap", 32'(bus.hitmap), 'h03);
    check("both_req_blocked", 32'(bus.req_ready), 0);
    nxt();
    check("both_req_ready_late", 32'(bus.req_ready), 1);
    exp_q.push_back(model_hit(8'hA5));
    nxt();
    bus.req_valid = 1'b0;
    check("both_user_req", 32'(bus.user_req), 1);
    check("both_addr", 32'(bus.addr), 'hA5);
    nxt();
    nxt();
    check("both_rsp_valid", 32'(bus.rsp_valid), 1);
    check("both_rsp_hit", 32'(bus.rsp_hit), 32'(model_hit(8'hA5)));

    // Reset during WAIT aborts the lookup and restores the table
    do_lookup(8'h11, 1'b0);
    reset = 1'b0;
    nxt();
    check("abort_rsp_valid", 32'(bus.rsp_valid), 0);
    check("abort_hitmap", 32'(bus.hitmap), 0);
    reset = 1'b1;
    nxt();
    check("reinit_os_req", 32'(bus.os_req), 1);
    check("reinit_hitmap", 32'(bus.hitmap), 'h03);
    nxt();
    check("reinit_no_rsp", 32'(bus.rsp_valid), 0);
    do_switch(2'd1, 8'h0C, 1'b1);

    // Switch to the already-active domain
`ifdef DAWG_SAME_DOMAIN_SKIP_EN
    do_switch(2'd1, 8'h0C, 1'b0);
    do_switch(2'd1, 8'h0C, 1'b0);
`else
    do_switch(2'd1, 8'h0C, 1'b1);
`endif

    nxt();
    check("sb_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
